// File: rtl/cronometro_param.sv
// Parametrised BCD stopwatch/timer: up-count with wrap pulse, down-count from a
// clamped BCD preset with end flag, and a display that can freeze while counting.
module cronometro_param #(
  parameter int NUM_DIGITOS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     conta,
  input  logic                     pausa,
  input  logic                     para,
  input  logic                     zera,
  input  logic                     modo,
  input  logic [4*NUM_DIGITOS-1:0] preset,
  output logic [4*NUM_DIGITOS-1:0] contagem,
  output logic [1:0]               estado,
  output logic                     estouro,
  output logic                     fim
);

  localparam int W = 4 * NUM_DIGITOS;

  typedef enum logic [1:0] {
    ZERADO    = 2'd0,
    CONTANDO  = 2'd1,
    CONGELADO = 2'd2,
    PARADO    = 2'd3
  } estado_t;

  estado_t        estado_q, estado_n;
  logic [W-1:0]   contador, contador_n;
  logic [W-1:0]   carga, incremento, decremento;
  logic           modo_ativo, modo_ativo_n;
  logic           estouro_n, fim_n;
  logic           conta_old, pausa_old, para_old, zera_old;
  logic           e_conta, e_pausa, e_para, e_zera;
  logic           todos_nove, vai_um, empresta;
  logic           contador_zero, decremento_zero;
  logic           contando, chega_zero, acao_botao;

  assign e_conta = conta & ~conta_old;
  assign e_pausa = pausa & ~pausa_old;
  assign e_para  = para  & ~para_old;
  assign e_zera  = zera  & ~zera_old;

  assign contador_zero   = (contador == '0);
  assign decremento_zero = (decremento == '0);

  // Out-of-range preset digits load as 9 so the counter always holds valid BCD.
  always_comb begin
    carga = '0;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      carga[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
    end
  end

  always_comb begin
    incremento = contador;
    vai_um     = 1'b1;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (vai_um) begin
        if (contador[4*i +: 4] == 4'd9) begin
          incremento[4*i +: 4] = 4'd0;
        end else begin
          incremento[4*i +: 4] = contador[4*i +: 4] + 4'd1;
          vai_um = 1'b0;
        end
      end
    end
    todos_nove = vai_um;
  end

  always_comb begin
    decremento = contador;
    empresta   = 1'b1;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (empresta) begin
        if (contador[4*i +: 4] == 4'd0) begin
          decremento[4*i +: 4] = 4'd9;
        end else begin
          decremento[4*i +: 4] = contador[4*i +: 4] - 4'd1;
          empresta = 1'b0;
        end
      end
    end
  end

  always_comb begin
    estado_n     = estado_q;
    contador_n   = contador;
    modo_ativo_n = modo_ativo;
    estouro_n    = 1'b0;
    chega_zero   = 1'b0;
    acao_botao   = 1'b0;
    contando     = tick && ((estado_q == CONTANDO) || (estado_q == CONGELADO));

    if (estado_q == ZERADO) begin
      modo_ativo_n = modo;
      contador_n   = modo ? carga : '0;
    end else if (contando) begin
      if (!modo_ativo) begin
        contador_n = incremento;
        estouro_n  = todos_nove;
      end else if (!contador_zero) begin
        contador_n = decremento;
        chega_zero = decremento_zero;
      end
    end

    // Only the highest-priority edge is considered; lower ones are dropped.
    if (e_zera) begin
      estado_n   = ZERADO;
      contador_n = modo ? carga : '0;
      acao_botao = 1'b1;
    end else if (e_conta) begin
      if ((estado_q != CONTANDO) && !(modo_ativo && contador_zero)) begin
        estado_n   = CONTANDO;
        acao_botao = 1'b1;
      end
    end else if (e_pausa) begin
      if (estado_q == CONTANDO) begin
        estado_n   = CONGELADO;
        acao_botao = 1'b1;
      end else if (estado_q == CONGELADO) begin
        estado_n   = CONTANDO;
        acao_botao = 1'b1;
      end
    end else if (e_para) begin
      if ((estado_q == CONTANDO) || (estado_q == CONGELADO)) begin
        estado_n   = PARADO;
        acao_botao = 1'b1;
      end
    end

    if (chega_zero && !acao_botao) begin
      estado_n = PARADO;
    end
    fim_n = (fim && !e_zera) || chega_zero;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= ZERADO;
      contador   <= '0;
      contagem   <= '0;
      estouro    <= 1'b0;
      fim        <= 1'b0;
      modo_ativo <= 1'b0;
      conta_old  <= 1'b1;
      pausa_old  <= 1'b1;
      para_old   <= 1'b1;
      zera_old   <= 1'b1;
    end else begin
      estado_q   <= estado_n;
      contador   <= contador_n;
      estouro    <= estouro_n;
      fim        <= fim_n;
      modo_ativo <= modo_ativo_n;
      conta_old  <= conta;
      pausa_old  <= pausa;
      para_old   <= para;
      zera_old   <= zera;
      if (estado_n != CONGELADO) begin
        contagem <= contador_n;
      end
    end
  end

  assign estado = estado_q;

endmodule

// File: doc/cronometro_param.md
Name: cronometro_param

Overview:
Parametrised BCD stopwatch/timer core, successor of the fixed 4-digit chronometer state machine. Supports N digits, up-count (stopwatch) and down-count (timer with BCD preset), lap-style display freeze, wrap and end-of-count flags. Single clock domain; the count rate comes from an external one-cycle `tick` strobe. Button inputs are already synchronised and debounced upstream; this block does edge detection only. Outputs drive the existing BCD-to-7-segment decoders.

Parameters:
NUM_DIGITOS, 4, number of BCD digits; digit 0 is least significant (tenths of a second); valid range 1..8.

Ports:
clock  in  1  system clock; all logic updates on its rising edge
reset  in  1  synchronous, active-high; full reset of all state
tick  in  1  one-cycle count enable, one pulse per count unit (0.1 s)
conta  in  1  start/resume button level
pausa  in  1  freeze/unfreeze display button level
para  in  1  stop button level
zera  in  1  clear button level
modo  in  1  0 = up-count, 1 = down-count; sampled only in ZERADO
preset  in  4*NUM_DIGITOS  BCD start value for down-count
contagem  out  4*NUM_DIGITOS  displayed BCD value
estado  out  2  current state: 0 ZERADO, 1 CONTANDO, 2 CONGELADO, 3 PARADO
estouro  out  1  one-cycle pulse on up-count wrap
fim  out  1  level; set when a down-count reaches zero

Behaviour:
- Reset values: estado=ZERADO; internal counter=0; contagem=0; estouro=0; fim=0; modo_ativo=0; all button "old" registers=1, so a button held through reset does not fire.
- Edge detect: edge_x = x & ~x_old, with x_old <= x every cycle. A rising level sampled in cycle n changes estado at the end of cycle n. A held button fires only once.
- Priority when edges coincide: zera > conta > pausa > para. Only the highest-priority edge acts; lower-priority edges in the same cycle are discarded.
- Transitions:
  - zera: any state -> ZERADO; clears fim.
  - conta: ZERADO/PARADO/CONGELADO -> CONTANDO; no effect in CONTANDO. Ignored when modo_ativo=1 and the counter is 0.
  - pausa: CONTANDO <-> CONGELADO; ignored in ZERADO and PARADO.
  - para: CONTANDO/CONGELADO -> PARADO; ignored otherwise.
- ZERADO: each cycle, modo_ativo <= modo, and the counter loads 0 (modo=0) or the clamped preset (modo=1). Clamp rule: any preset digit >9 loads as 9.
- Counting:
  - Counting happens only when the registered estado is CONTANDO or CONGELADO and tick=1. A tick in the same cycle as the transition into CONTANDO is not counted.
  - Up-count: BCD ripple increment. All-9s -> all-0s, estouro=1 for that one cycle, counting continues.
  - Down-count: BCD ripple decrement (a digit at 0 borrows and becomes 9). On the tick where the result is 0: fim<=1 and estado<=PARADO in the same edge. If a button edge coincides, the button transition wins, except that fim is still set.
- Display:
  - contagem is registered and loaded with the counter's next value whenever the next estado != CONGELADO, so it has zero extra latency versus the counter.
  - In CONGELADO, contagem holds while the counter keeps running.
  - Leaving CONGELADO via pausa, conta or para updates contagem in that same edge.
- Reset mid-count: all state returns to reset values at the next edge; buttons and tick are ignored in that cycle.

Test Plan:
1. NUM_DIGITOS=4, modo=0: reset, pulse conta, apply 10 ticks -> contagem=0x0010, estado=1; apply pulse para, then 5 ticks -> contagem stays 0x0010, estado=3.
2. Up-count wrap: start at 9999 via 9999 ticks, then one more tick -> contagem=0x0000, estouro high exactly one cycle, estado remains 1.
3. Freeze: count to 0x0012, press pausa, 7 ticks -> contagem held 0x0012, estado=2; press pausa -> contagem=0x0019 in the same edge, estado=1.
4. Down-count: modo=1, preset=0x0103, conta, 103 ticks -> contagem=0x0000, fim=1, estado=3; conta is ignored; zera -> fim=0, contagem=0x0103.
5. Simultaneous edges: in CONTANDO, assert zera and para rising in the same cycle -> estado=0 and the counter is cleared; assert conta held through reset -> no start after reset deasserts.
6. Clamp/param: NUM_DIGITOS=2, modo=1, preset=0xA5 -> after ZERADO contagem=0x95; 1 tick after conta -> 0x94.
